// File: rtl/cic_interpolator.sv
`default_nettype none
// ============================================================================
// Module      : cic_interpolator
// Description : CIC interpolation filter with valid/ready handshakes on both
//               sides. CIC_N comb stages run at the low (input) rate in front
//               of a hold register; the held sample is zero-stuffed by CIC_R
//               and fed through CIC_N integrators at the high (output) rate.
//
// Ports:
//   clk             in   clock, all logic on the rising edge
//   reset_n         in   synchronous active-low reset
//   samp_inp_data   in   low-rate input sample, signed, SAMP_WIDTH bits
//   samp_inp_valid  in   input sample present
//   samp_inp_ready  out  input sample accepted this cycle (combinational)
//   samp_out_data   out  high-rate output sample, signed, OUT_WIDTH bits
//   samp_out_valid  out  output sample present
//   samp_out_ready  in   downstream accepts the output this cycle
//
// Revision    : 1.0 - initial release
// ============================================================================
module cic_interpolator #(
    parameter int  SAMP_WIDTH = 8,
    parameter int  CIC_R      = 4,
    parameter int  CIC_N      = 3,
    parameter int  CIC_M      = 1,
    localparam int REG_WIDTH  = SAMP_WIDTH + CIC_N * $clog2(CIC_R * CIC_M),
    localparam int OUT_WIDTH  = REG_WIDTH - $clog2(CIC_R)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic signed [SAMP_WIDTH-1:0] samp_inp_data,
    input  logic                         samp_inp_valid,
    output logic                         samp_inp_ready,
    output logic signed [OUT_WIDTH-1:0]  samp_out_data,
    output logic                         samp_out_valid,
    input  logic                         samp_out_ready
);

    localparam int                  PH_WIDTH = $clog2(CIC_R);
    localparam logic [PH_WIDTH-1:0] PH_LAST  = PH_WIDTH'(CIC_R - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                state_q,    state_d;
    logic [PH_WIDTH-1:0]   phase_q,    phase_d;
    logic [REG_WIDTH-1:0]  hold_q,     hold_d;
    logic [REG_WIDTH-1:0]  comb_dly_q [CIC_N][CIC_M];
    logic [REG_WIDTH-1:0]  comb_dly_d [CIC_N][CIC_M];
    logic [REG_WIDTH-1:0]  integ_q    [CIC_N];
    logic [REG_WIDTH-1:0]  integ_d    [CIC_N];
    logic [OUT_WIDTH-1:0]  out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;

    // ------------------------------------------------------------------
    // Handshake / control
    // ------------------------------------------------------------------
    logic adv;
    logic last_phase;
    logic accept;

    // The integrators may step whenever the output register is empty or
    // is being drained this same cycle.
    assign adv        = (state_q == ST_EMIT) && (!out_valid_q || samp_out_ready);
    assign last_phase = (phase_q == PH_LAST);

    // Taking a new sample on the last phase keeps the pipe full without a
    // bubble; this makes ready depend combinationally on samp_out_ready.
    assign samp_inp_ready = reset_n && ((state_q == ST_IDLE) || (last_phase && adv));
    assign accept         = samp_inp_valid && samp_inp_ready;

    // ------------------------------------------------------------------
    // Comb chain (combinational, low rate)
    // ------------------------------------------------------------------
    logic [REG_WIDTH-1:0] comb_in [CIC_N];
    logic [REG_WIDTH-1:0] comb_out;

    always_comb begin : comb_chain
        logic [REG_WIDTH-1:0] acc;
        acc = {{(REG_WIDTH - SAMP_WIDTH){samp_inp_data[SAMP_WIDTH-1]}}, samp_inp_data};
        for (int k = 0; k < CIC_N; k++) begin
            comb_in[k] = acc;
            acc        = acc - comb_dly_q[k][CIC_M-1];
        end
        comb_out = acc;
    end

    // Delay lines and hold register only move when a sample is accepted.
    always_comb begin : comb_next
        comb_dly_d = comb_dly_q;
        hold_d     = hold_q;
        if (accept) begin
            hold_d = comb_out;
            for (int k = 0; k < CIC_N; k++) begin
                comb_dly_d[k][0] = comb_in[k];
                for (int m = 1; m < CIC_M; m++) begin
                    comb_dly_d[k][m] = comb_dly_q[k][m-1];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin : seq_next
        state_d = state_q;
        phase_d = phase_q;
        if (accept) begin
            state_d = ST_EMIT;
            phase_d = '0;
        end else if (adv) begin
            if (last_phase) begin
                state_d = ST_IDLE;
                phase_d = '0;
            end else begin
                phase_d = phase_q + PH_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Integrators (high rate, zero-stuffed input)
    // ------------------------------------------------------------------
    logic [REG_WIDTH-1:0] integ_x;

    assign integ_x = (phase_q == '0) ? hold_q : '0;

    // Every stage uses the pre-update value of its predecessor, so the chain
    // is a register pipeline of CIC_N advances. Wrap-around is intentional.
    always_comb begin : integ_next
        integ_d = integ_q;
        if (adv) begin
            integ_d[0] = integ_q[0] + integ_x;
            for (int k = 1; k < CIC_N; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic [REG_WIDTH-1:0] integ_last;
    logic                 unused_integ_msbs;

    assign integ_last = integ_q[CIC_N-1];
    // Upper bits only carry the modular wrap; the full-precision result
    // always fits in OUT_WIDTH.
    assign unused_integ_msbs = ^integ_last[REG_WIDTH-1:OUT_WIDTH];

    always_comb begin : out_next
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (adv) begin
            out_data_d  = integ_last[OUT_WIDTH-1:0];
            out_valid_d = 1'b1;
        end else if (samp_out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign samp_out_data  = out_data_q;
    // Gated so that nothing is transferred during a reset cycle.
    assign samp_out_valid = out_valid_q && reset_n;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            hold_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < CIC_N; k++) begin
                integ_q[k] <= '0;
                for (int m = 0; m < CIC_M; m++) begin
                    comb_dly_q[k][m] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            hold_q      <= hold_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            integ_q     <= integ_d;
            comb_dly_q  <= comb_dly_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cic_interpolator.sv
`default_nettype none
// ============================================================================
// Module      : tb_cic_interpolator
// Description : Self-checking bench for cic_interpolator. Every transferred
//               output is compared with a convolution model: the accepted
//               inputs are zero-stuffed by R and convolved with the CIC
//               impulse response (a length-R*M box convolved with itself N
//               times), delayed by N output samples.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cic_interpolator;

    localparam int SAMP_WIDTH = 8;
    localparam int CIC_R      = 4;
    localparam int CIC_N      = 3;
    localparam int CIC_M      = 1;
    localparam int OUT_WIDTH  = 12;
    localparam int RM         = CIC_R * CIC_M;
    localparam int HLEN       = CIC_N * (RM - 1) + 1;
    localparam int TIMEOUT    = 2000;

    logic                         clk;
    logic                         reset_n;
    logic signed [SAMP_WIDTH-1:0] samp_inp_data;
    logic                         samp_inp_valid;
    logic                         samp_inp_ready;
    logic signed [OUT_WIDTH-1:0]  samp_out_data;
    logic                         samp_out_valid;
    logic                         samp_out_ready;

    cic_interpolator #(
        .SAMP_WIDTH (SAMP_WIDTH),
        .CIC_R      (CIC_R),
        .CIC_N      (CIC_N),
        .CIC_M      (CIC_M)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .samp_inp_data  (samp_inp_data),
        .samp_inp_valid (samp_inp_valid),
        .samp_inp_ready (samp_inp_ready),
        .samp_out_data  (samp_out_data),
        .samp_out_valid (samp_out_valid),
        .samp_out_ready (samp_out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Bookkeeping and reference model
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;
    int h [HLEN];
    int in_hist [$];
    int got_q [$];
    bit rand_ready = 1'b0;
    bit stall_pending = 1'b0;
    logic [OUT_WIDTH-1:0] stall_data = '0;
    int impulse_exp [14] = '{0, 0, 0, 1, 3, 6, 10, 12, 12, 10, 6, 3, 1, 0};

    task automatic check_value(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void build_response();
        int tmp [HLEN];
        int len;
        for (int i = 0; i < HLEN; i++) h[i] = 0;
        h[0] = 1;
        len  = 1;
        for (int s = 0; s < CIC_N; s++) begin
            for (int i = 0; i < HLEN; i++) tmp[i] = 0;
            for (int i = 0; i < len; i++)
                for (int d = 0; d < RM; d++)
                    tmp[i + d] += h[i];
            for (int i = 0; i < HLEN; i++) h[i] = tmp[i];
            len += RM - 1;
        end
    endfunction

    // Expected value of high-rate output sample j.
    function automatic int model_out(input int j);
        int acc = 0;
        int n;
        for (int k = 0; k < HLEN; k++) begin
            n = j - CIC_N - k;
            if (n >= 0 && (n % CIC_R) == 0 && (n / CIC_R) < in_hist.size())
                acc += h[k] * in_hist[n / CIC_R];
        end
        return acc;
    endfunction

    // ------------------------------------------------------------------
    // Monitor: samples at the falling edge what the next rising edge sees
    // ------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                in_hist.delete();
                got_q.delete();
                stall_pending = 1'b0;
            end else begin
                if (stall_pending) begin
                    check_value("stall_valid", int'(samp_out_valid), 1);
                    check_value("stall_data", int'(samp_out_data), int'($signed(stall_data)));
                end
                if (samp_inp_valid && samp_inp_ready)
                    in_hist.push_back(int'(samp_inp_data));
                if (samp_out_valid && samp_out_ready) begin
                    check_value($sformatf("out_sample_%0d", got_q.size()),
                                int'(samp_out_data), model_out(got_q.size()));
                    got_q.push_back(int'(samp_out_data));
                end
                stall_pending = samp_out_valid && !samp_out_ready;
                stall_data    = samp_out_data;
            end
        end
    end

    // Downstream ready: always high, or random when backpressure is enabled.
    initial begin
        samp_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            samp_out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus tasks (called with time aligned #1 after a rising edge)
    // ------------------------------------------------------------------
    task automatic send(input int value);
        bit hs = 1'b0;
        int cnt = 0;
        samp_inp_valid = 1'b1;
        samp_inp_data  = SAMP_WIDTH'(value);
        while (!hs && cnt < TIMEOUT) begin
            @(negedge clk);
            hs = samp_inp_ready;
            @(posedge clk);
            #1;
            cnt++;
        end
        check_value("inp_accept", int'(hs), 1);
    endtask

    task automatic wait_outputs(input int n);
        int cnt = 0;
        while (got_q.size() < n && cnt < TIMEOUT) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check_value($sformatf("out_count_ge_%0d", n), int'(got_q.size() >= n), 1);
    endtask

    task automatic do_reset();
        samp_inp_valid = 1'b0;
        samp_inp_data  = '0;
        reset_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_inp_ready", int'(samp_inp_ready), 0);
        check_value("rst_out_valid", int'(samp_out_valid), 0);
        check_value("rst_out_data", int'(samp_out_data), 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_value("idle_inp_ready", int'(samp_inp_ready), 1);
        check_value("idle_out_valid", int'(samp_out_valid), 0);
    endtask

    task automatic run_impulse(input string tag);
        send(1);
        send(0);
        send(0);
        send(0);
        samp_inp_valid = 1'b0;
        wait_outputs(4 * CIC_R);
        for (int i = 0; i < 14; i++)
            check_value($sformatf("%s_%0d", tag, i), got_q[i], impulse_exp[i]);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int n_rdy;
        int n_vld;
        reset_n        = 1'b0;
        samp_inp_valid = 1'b0;
        samp_inp_data  = '0;
        build_response();
        @(posedge clk);
        #1;

        // Impulse with downstream always ready
        do_reset();
        run_impulse("impulse");

        // DC: +127 then -128, steady-state values
        do_reset();
        repeat (8) send(127);
        repeat (8) send(-128);
        samp_inp_valid = 1'b0;
        wait_outputs(64);
        for (int i = 24; i < 28; i++)
            check_value($sformatf("dc_pos_%0d", i), got_q[i], 2032);
        for (int i = 56; i < 60; i++)
            check_value($sformatf("dc_neg_%0d", i), got_q[i], -2048);

        // Impulse under random backpressure
        do_reset();
        rand_ready = 1'b1;
        run_impulse("bp");
        rand_ready = 1'b0;

        // Throughput with continuous input and ready downstream
        do_reset();
        samp_inp_valid = 1'b1;
        repeat (8) begin
            samp_inp_data = SAMP_WIDTH'($urandom);
            @(posedge clk);
            #1;
        end
        n_rdy = 0;
        n_vld = 0;
        repeat (40) begin
            @(negedge clk);
            n_rdy += int'(samp_inp_ready);
            n_vld += int'(samp_out_valid);
            @(posedge clk);
            #1;
            samp_inp_data = SAMP_WIDTH'($urandom);
        end
        samp_inp_valid = 1'b0;
        check_value("tput_inp_ready", n_rdy, 10);
        check_value("tput_out_valid", n_vld, 40);
        repeat (8) @(posedge clk);
        #1;

        // Reset asserted at phase 2 of an emission
        do_reset();
        send(1);
        samp_inp_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_value("midrst_inp_ready", int'(samp_inp_ready), 0);
        check_value("midrst_out_valid", int'(samp_out_valid), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        check_value("postrst_out_valid", int'(samp_out_valid), 0);
        check_value("postrst_out_data", int'(samp_out_data), 0);
        check_value("postrst_inp_ready", int'(samp_inp_ready), 1);
        run_impulse("rst_impulse");

        // Random samples, random gaps, random backpressure
        do_reset();
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(int'($urandom_range(0, 255)) - 128);
            if ($urandom_range(0, 3) == 0) begin
                samp_inp_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        repeat (3) send(0);
        samp_inp_valid = 1'b0;
        wait_outputs(43 * CIC_R);
        rand_ready = 1'b0;

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cic_interpolator.md
CIC_INTERPOLATOR -- requirements
Module: cic_interpolator

Interface
REQ-001 SHALL have parameter SAMP_WIDTH, default 8: input sample width, signed two's complement.
REQ-002 SHALL have parameter CIC_R, default 4: interpolation ratio; power of two, >= 2.
REQ-003 SHALL have parameter CIC_N, default 3: number of comb stages and number of integrator stages, >= 1.
REQ-004 SHALL have parameter CIC_M, default 1: comb differential delay, >= 1.
REQ-005 SHALL derive localparam REG_WIDTH = SAMP_WIDTH + CIC_N*clog2(CIC_R*CIC_M) for all internal registers, and OUT_WIDTH = REG_WIDTH - clog2(CIC_R).
REQ-006 SHALL have port clk, input, 1 bit: clock; all logic on its rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-008 SHALL have port samp_inp_data, input, SAMP_WIDTH bits, signed: low-rate input sample.
REQ-009 SHALL have port samp_inp_valid, input, 1 bit: input sample present.
REQ-010 SHALL have port samp_inp_ready, output, 1 bit: block accepts the input this cycle.
REQ-011 SHALL have port samp_out_data, output, OUT_WIDTH bits, signed: high-rate output sample.
REQ-012 SHALL have port samp_out_valid, output, 1 bit: output sample present.
REQ-013 SHALL have port samp_out_ready, input, 1 bit: downstream accepts the output this cycle.

Function
REQ-014 SHALL accept an input when samp_inp_valid && samp_inp_ready, and transfer an output when samp_out_valid && samp_out_ready.
REQ-015 SHALL run a comb chain combinationally on samp_inp_data: stage k output = stage k input - that stage's input from CIC_M accepts earlier, at REG_WIDTH and sign-extended. Each stage SHALL keep a CIC_M-deep delay line that shifts only on accept.
REQ-016 SHALL register the comb chain output into hold register H on accept.
REQ-017 SHALL implement two states, IDLE and EMIT, with a phase counter 0..CIC_R-1.
REQ-018 SHALL define adv = (state==EMIT) && (!samp_out_valid || samp_out_ready).
REQ-019 SHALL drive samp_inp_ready = (state==IDLE) || (phase==CIC_R-1 && adv); this is combinational from samp_out_ready.
REQ-020 On accept SHALL go to EMIT with phase=0, including a back-to-back accept on the final phase.
REQ-021 On adv SHALL:
  - increment phase;
  - when phase==CIC_R-1 and no accept occurs, go to IDLE with phase=0.
REQ-022 SHALL zero-stuff: integrator input x = H when phase==0, else 0.
REQ-023 On adv SHALL update integrators as I1 <= I1 + x and Ik <= Ik + I(k-1) using pre-update values, with modular REG_WIDTH wrap. Integrators SHALL hold when adv is low.
REQ-024 On adv SHALL load the output register with the low OUT_WIDTH bits of I_N and set samp_out_valid=1.
REQ-025 SHALL clear samp_out_valid when samp_out_ready=1 and adv=0.
REQ-026 SHALL keep samp_out_data and samp_out_valid stable while samp_out_valid=1 && samp_out_ready=0; phase and integrators SHALL freeze during this stall.
REQ-027 SHALL make output sample j reflect x from advance j-CIC_N, i.e. CIC_N advances of pipeline latency plus the output register.
REQ-028 SHALL give a DC gain of (CIC_R*CIC_M)^CIC_N / CIC_R, with the full-precision result always fitting OUT_WIDTH.
REQ-029 While IDLE with no input SHALL hold all integrator state; no output SHALL be produced.

Reset
REQ-030 While reset_n=0 SHALL clear:
  - state=IDLE, phase=0;
  - H, all comb delay lines, all integrators;
  - samp_out_data=0, samp_out_valid=0.
REQ-031 While reset_n=0 SHALL drive samp_inp_ready=0, and SHALL return to the REQ-030 values on reset asserted mid-EMIT or mid-stall, with no output transferred that cycle.

Verification (SAMP_WIDTH=8, R=4, N=3, M=1, OUT_WIDTH=12)
REQ-032 Impulse: input 1 then zeros, samp_out_ready=1 -> after 3 zero outputs, outputs 1,3,6,10,12,12,10,6,3,1, then 0.
REQ-033 DC: constant input +127, then -128 -> steady outputs 2032, then -2048, with no wrap error.
REQ-034 Backpressure: samp_out_ready toggled randomly -> output sequence identical to REQ-032, and samp_out_data stable during every stall.
REQ-035 Throughput: samp_inp_valid=1 continuously, ready=1 -> samp_inp_ready high exactly 1 of every 4 cycles, and samp_out_valid=1 every cycle after fill.
REQ-036 Reset mid-EMIT at phase 2 -> next cycle all outputs 0 and samp_inp_ready=1; a subsequent impulse reproduces REQ-032.
